sort_stream_ctrl: RTL and testbench

//  Sequencer for the odd-even transposition sorter.

---
 rtl/sort_stream_ctrl.sv | 102 ++++++++++
 tb/tb_sort_stream_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_ctrl.sv
// Sequencer around an odd-even transposition sorter: collects one job from a serial stream,
// runs the sorter with a timeout guard, then replays the sorted vector one element per beat.
module sort_stream_ctrl #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned SEQ_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH-1:0]           s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [BIT_WIDTH-1:0]           m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic                           srt_reset,
  output logic                           srt_start,
  output logic [BIT_WIDTH*SEQ_WIDTH-1:0] srt_in,
  input  logic [BIT_WIDTH*SEQ_WIDTH-1:0] srt_out,
  input  logic                           srt_valid,
  output logic                           busy,
  output logic                           err_timeout
);

  localparam int unsigned CntW = $clog2(SEQ_WIDTH);
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(SEQ_WIDTH - 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StClear, StSort, StDrain} state_e;

  state_e                         state_q;
  logic [CntW-1:0]                cnt_q;
  logic [CntW-1:0]                idx_q;
  logic [TmrW-1:0]                timer_q;
  logic [BIT_WIDTH*SEQ_WIDTH-1:0] srt_in_q;
  logic [BIT_WIDTH*SEQ_WIDTH-1:0] res_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
      srt_in_q <= '0;
      res_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_valid) begin
            srt_in_q[0 +: BIT_WIDTH] <= s_data;
            cnt_q                    <= CntW'(1);
            state_q                  <= StLoad;
          end
        end
        StLoad: begin
          if (s_valid) begin
            srt_in_q[BIT_WIDTH*cnt_q +: BIT_WIDTH] <= s_data;
            cnt_q                                  <= cnt_q + 1'b1;
            if (cnt_q == LastIdx) state_q <= StClear;
          end
        end
        StClear: begin
          timer_q <= '0;
          state_q <= StSort;
        end
        StSort: begin
          // A result arriving on the expiry cycle still wins over the timeout.
          if (srt_valid) begin
            res_q   <= srt_out;
            idx_q   <= '0;
            state_q <= StDrain;
          end else if (timer_q == TmrLast) begin
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StDrain: begin
          if (m_ready) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == LastIdx) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_ready     = (state_q == StIdle) || (state_q == StLoad);
  assign busy        = (state_q != StIdle);
  assign srt_reset   = (state_q != StSort);
  assign srt_start   = (state_q == StSort);
  assign srt_in      = srt_in_q;
  assign m_valid     = (state_q == StDrain);
  assign m_last      = (state_q == StDrain) && (idx_q == LastIdx);
  assign m_data      = res_q[BIT_WIDTH*idx_q +: BIT_WIDTH];
  // Pulses in the final SORT cycle so the controller is idle on the very next cycle.
  assign err_timeout = (state_q == StSort) && (timer_q == TmrLast) && !srt_valid;

endmodule

// File: tb/tb_sort_stream_ctrl.sv
// Bench for sort_stream_ctrl: table of directed jobs, hand-written timeout sequence and random
// jobs, all checked against a sorter model and a plain insertion-sort reference.
module tb_sort_stream_ctrl;

  localparam int BW  = 8;
  localparam int SEQ = 16;
  localparam int TMO = 64;

  typedef logic [0:SEQ-1][BW-1:0] vec_t;
  typedef struct {
    vec_t din;
    vec_t dout;
    int   gap;
    int   rmode;
    int   lat;
    int   abort;
    bit   glitch;
  } job_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [BW-1:0]     s_data;
  logic              s_valid;
  logic              s_ready;
  logic [BW-1:0]     m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              srt_reset;
  logic              srt_start;
  logic [BW*SEQ-1:0] srt_in;
  logic [BW*SEQ-1:0] srt_out;
  logic              srt_valid;
  logic              busy;
  logic              err_timeout;

  int vecs = 0;
  int miss = 0;

  sort_stream_ctrl #(.BIT_WIDTH(BW), .SEQ_WIDTH(SEQ), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .srt_reset  (srt_reset),
    .srt_start  (srt_start),
    .srt_in     (srt_in),
    .srt_out    (srt_out),
    .srt_valid  (srt_valid),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic vec_t sort_vec(input vec_t a);
    vec_t r;
    logic [BW-1:0] t;
    r = a;
    for (int i = 1; i < SEQ; i++)
      for (int j = i; j > 0 && r[j-1] > r[j]; j--) begin
        t = r[j]; r[j] = r[j-1]; r[j-1] = t;
      end
    return r;
  endfunction

  function automatic logic [BW*SEQ-1:0] pack(input vec_t v);
    logic [BW*SEQ-1:0] p;
    p = '0;
    for (int k = 0; k < SEQ; k++) p[BW*k +: BW] = v[k];
    return p;
  endfunction

  // Sorter model: valid after lat cycles of SORT (or never), garbage on srt_out otherwise.
  int                scnt = 0;
  int                lat = 16;
  bit                never = 1'b0;
  bit                glitch = 1'b0;
  logic              model_valid;
  vec_t              mu, ms;
  logic [BW*SEQ-1:0] srt_sorted;

  always @(posedge clk) begin
    if (srt_reset) scnt <= 0;
    else           scnt <= scnt + 1;
  end

  always_comb begin
    mu = '0;
    for (int k = 0; k < SEQ; k++) mu[k] = srt_in[BW*k +: BW];
    ms = sort_vec(mu);
    srt_sorted = pack(ms);
  end

  assign model_valid = !never && !srt_reset && (scnt == lat);
  assign srt_valid   = model_valid || glitch;
  assign srt_out     = model_valid ? srt_sorted : {SEQ{8'hA5}};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input vec_t d, input int gap, input bit gl);
    if (gl) begin
      glitch = 1'b1;
      step();
      glitch = 1'b0;
      chk("idle_glitch_busy", busy, 0);
      chk("idle_glitch_ready", s_ready, 1);
    end
    for (int i = 0; i < SEQ; i++) begin
      s_valid = 1'b1;
      s_data  = d[i];
      if (gl && i == 5) glitch = 1'b1;
      chk("load_s_ready", s_ready, 1);
      step();
      glitch  = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      if (i < SEQ - 1)
        for (int g = 0; g < gap; g++) begin
          chk("gap_s_ready", s_ready, 1);
          step();
        end
    end
    chk("clear_s_ready", s_ready, 0);
    chk("clear_srt_start", srt_start, 0);
    chk("clear_srt_reset", srt_reset, 1);
    chk("clear_srt_in", srt_in, pack(d));
    step();
    chk("sort_srt_start", srt_start, 1);
    chk("sort_srt_reset", srt_reset, 0);
  endtask

  task automatic run_job(input job_t j);
    int n;
    int k;
    lat   = j.lat;
    never = 1'b0;
    load(j.din, j.gap, j.glitch);
    n = 0;
    while (!m_valid && n < 200) begin
      chk("sort_no_timeout", err_timeout, 0);
      step();
      n++;
    end
    chk("result_latency", n, j.lat + 1);
    k = 0;
    n = 0;
    while (k < SEQ && n < 400) begin
      case (j.rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (n % 2 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      chk("drain_m_valid", m_valid, 1);
      chk("drain_m_data", m_data, j.dout[k]);
      chk("drain_m_last", m_last, k == SEQ - 1);
      if (k == j.abort) begin
        m_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("abort_m_valid", m_valid, 0);
        chk("abort_srt_reset", srt_reset, 1);
        chk("abort_busy", busy, 0);
        chk("abort_s_ready", s_ready, 1);
        chk("abort_m_data", m_data, 0);
        chk("abort_srt_in", srt_in, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        return;
      end
      step();
      if (m_ready) k++;
      n++;
    end
    m_ready = 1'b0;
    chk("drain_count", k, SEQ);
    chk("done_busy", busy, 0);
    chk("done_s_ready", s_ready, 1);
    chk("done_m_valid", m_valid, 0);
  endtask

  function automatic job_t mk(input vec_t din, input vec_t dout, input int gap, input int rmode,
                              input int l, input int abort, input bit gl);
    job_t j;
    j.din = din; j.dout = dout; j.gap = gap; j.rmode = rmode;
    j.lat = l; j.abort = abort; j.glitch = gl;
    return j;
  endfunction

  job_t tbl [6];
  vec_t v_desc, v_inc, v_dup, v_dup_s, v_mix, v_mix_s;

  initial begin
    bit mv_seen;
    v_desc  = {8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9, 8'd8,
               8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    v_inc   = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7,
               8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
    v_dup   = {8'd3, 8'd2, 8'd3, 8'd8, 8'd5, 8'd6, 8'd4, 8'd1,
               8'd3, 8'd3, 8'd0, 8'd9, 8'd9, 8'd7, 8'd2, 8'd1};
    v_dup_s = {8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3,
               8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd9};
    v_mix   = {8'd200, 8'd7, 8'd7, 8'd255, 8'd0, 8'd128, 8'd64, 8'd1,
               8'd99, 8'd50, 8'd50, 8'd3, 8'd180, 8'd2, 8'd254, 8'd10};
    v_mix_s = {8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd7, 8'd10, 8'd50,
               8'd50, 8'd64, 8'd99, 8'd128, 8'd180, 8'd200, 8'd254, 8'd255};
    tbl[0] = mk(v_desc, v_inc,   0, 0, 16, -1, 1'b0);
    tbl[1] = mk(v_dup,  v_dup_s, 0, 1, 16, -1, 1'b0);
    tbl[2] = mk(v_mix,  v_mix_s, 3, 0, 16, -1, 1'b0);
    tbl[3] = mk(v_desc, v_inc,   0, 2, TMO - 1, -1, 1'b0);
    tbl[4] = mk(v_dup,  v_dup_s, 0, 1, 16, 5, 1'b0);
    tbl[5] = mk(v_mix,  v_mix_s, 1, 0, 0, -1, 1'b1);

    reset = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #2;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_srt_reset", srt_reset, 1);
    chk("rst_srt_start", srt_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_srt_in", srt_in, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    for (int t = 0; t < 6; t++) run_job(tbl[t]);

    // Hung sorter: error in the last SORT cycle, idle right after, no output.
    never = 1'b1;
    mv_seen = 1'b0;
    load(v_mix, 0, 1'b0);
    for (int c = 0; c < TMO; c++) begin
      chk("tmo_err", err_timeout, c == TMO - 1);
      chk("tmo_busy", busy, 1);
      if (m_valid) mv_seen = 1'b1;
      step();
    end
    chk("tmo_err_cleared", err_timeout, 0);
    chk("tmo_busy_after", busy, 0);
    chk("tmo_s_ready_after", s_ready, 1);
    repeat (4) begin
      if (m_valid) mv_seen = 1'b1;
      step();
    end
    chk("tmo_no_m_valid", mv_seen, 0);
    never = 1'b0;

    for (int r = 0; r < 12; r++) begin
      job_t j;
      for (int k = 0; k < SEQ; k++) j.din[k] = 8'($urandom);
      j.dout   = sort_vec(j.din);
      j.gap    = $urandom_range(0, 2);
      j.rmode  = 2;
      j.lat    = $urandom_range(0, 40);
      j.abort  = -1;
      j.glitch = 1'($urandom_range(0, 1));
      run_job(j);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", vecs);
    $fatal(1, "watchdog expired");
  end

endmodule
